// File: rtl/pipelined_addsub_unit.sv
// Pipelined add/subtract unit: one SEG_W-bit segment is resolved per stage with the
// carry registered in between, plus signed saturation, carry/overflow/zero flags and a tag.
module pipelined_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);
  localparam int NSEG = WIDTH / SEG_W;

  if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_bad_params
    $error("pipelined_addsub_unit: WIDTH must be a nonzero multiple of SEG_W");
  end

  logic [WIDTH-1:0] b_mod;
  assign b_mod = op[0] ? ~B : B;

  logic [SEG_W-1:0] last_a;
  logic [SEG_W-1:0] last_b;
  logic             last_cin;
  logic             last_valid;
  logic             last_sat;
  logic [TAG_W-1:0] last_tag;
  logic [SEG_W:0]   last_sum;
  logic [WIDTH-1:0] raw;

  assign last_sum = {1'b0, last_a} + {1'b0, last_b} + {{SEG_W{1'b0}}, last_cin};

  if (NSEG == 1) begin : g_single
    assign last_a     = A;
    assign last_b     = b_mod;
    assign last_cin   = op[0];
    assign last_valid = in_valid;
    assign last_sat   = op[1];
    assign last_tag   = tag_in;
    assign raw        = last_sum[SEG_W-1:0];
  end else begin : g_multi
    for (genvar k = 0; k < NSEG - 1; k++) begin : g_stage
      localparam int LO = (k + 1) * SEG_W;
      localparam int HI = WIDTH - LO;

      logic [HI+SEG_W-1:0] a_in;
      logic [HI+SEG_W-1:0] b_in;
      logic                cin_in;
      logic                valid_in;
      logic                sat_in;
      logic [TAG_W-1:0]    tag_d;
      logic [LO-1:0]       sum_d;
      logic [SEG_W:0]      seg_sum;

      logic [LO-1:0]       sum_q;
      logic [HI-1:0]       a_q;
      logic [HI-1:0]       b_q;
      logic                carry_q;
      logic                valid_q;
      logic                sat_q;
      logic [TAG_W-1:0]    tag_q;

      assign seg_sum = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]}
                     + {{SEG_W{1'b0}}, cin_in};

      // Only op[1] travels down the pipe; op[0] is fully consumed as B inversion and carry-in.
      if (k == 0) begin : g_first
        assign a_in     = A;
        assign b_in     = b_mod;
        assign cin_in   = op[0];
        assign valid_in = in_valid;
        assign sat_in   = op[1];
        assign tag_d    = tag_in;
        assign sum_d    = seg_sum[SEG_W-1:0];
      end else begin : g_next
        assign a_in     = g_stage[k-1].a_q;
        assign b_in     = g_stage[k-1].b_q;
        assign cin_in   = g_stage[k-1].carry_q;
        assign valid_in = g_stage[k-1].valid_q;
        assign sat_in   = g_stage[k-1].sat_q;
        assign tag_d    = g_stage[k-1].tag_q;
        assign sum_d    = {seg_sum[SEG_W-1:0], g_stage[k-1].sum_q};
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sum_q   <= '0;
          a_q     <= '0;
          b_q     <= '0;
          carry_q <= 1'b0;
          valid_q <= 1'b0;
          sat_q   <= 1'b0;
          tag_q   <= '0;
        end else if (!stall) begin
          sum_q   <= sum_d;
          a_q     <= a_in[HI+SEG_W-1:SEG_W];
          b_q     <= b_in[HI+SEG_W-1:SEG_W];
          carry_q <= seg_sum[SEG_W];
          valid_q <= valid_in;
          sat_q   <= sat_in;
          tag_q   <= tag_d;
        end
      end
    end

    assign last_a     = g_stage[NSEG-2].a_q;
    assign last_b     = g_stage[NSEG-2].b_q;
    assign last_cin   = g_stage[NSEG-2].carry_q;
    assign last_valid = g_stage[NSEG-2].valid_q;
    assign last_sat   = g_stage[NSEG-2].sat_q;
    assign last_tag   = g_stage[NSEG-2].tag_q;
    assign raw        = {last_sum[SEG_W-1:0], g_stage[NSEG-2].sum_q};
  end

  logic             c_msb;
  logic             ovf_d;
  logic [WIDTH-1:0] res_d;

  assign c_msb = last_sum[SEG_W-1] ^ last_a[SEG_W-1] ^ last_b[SEG_W-1];
  assign ovf_d = c_msb ^ last_sum[SEG_W];

  // On overflow both operand signs agree, so A's sign alone picks the clamp direction.
  always_comb begin
    res_d = raw;
    if (last_sat && ovf_d) begin
      res_d = last_a[SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      tag_out   <= '0;
    end else if (!stall) begin
      out_valid <= last_valid;
      if (last_valid) begin
        result  <= res_d;
        cout    <= last_sum[SEG_W];
        ovf     <= ovf_d;
        zero    <= (res_d == '0);
        tag_out <= last_tag;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Bench for pipelined_addsub_unit: a queue-based reference model compared every cycle,
// hand-computed directed cases, stall/reset scenarios and randomized traffic.
module tb_pipelined_addsub_unit;
  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int TAG_W = 5;
  localparam int NSEG  = WIDTH / SEG_W;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic             clock    = 1'b0;
  logic             reset    = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a_in     = '0;
  logic [WIDTH-1:0] b_in     = '0;
  logic [1:0]       op       = '0;
  logic [TAG_W-1:0] tag_in   = '0;
  logic             stall    = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] tag_out;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  pipelined_addsub_unit #(.WIDTH(WIDTH), .SEG_W(SEG_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .A(a_in), .B(b_in), .op(op),
    .tag_in(tag_in), .stall(stall), .out_valid(out_valid), .result(result), .cout(cout),
    .ovf(ovf), .zero(zero), .tag_out(tag_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference arithmetic straight from integer semantics.
  function automatic void model_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                                   output logic [31:0] r, output logic c, output logic v,
                                   output logic z);
    longint sa, sb, exact;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    exact = o[0] ? sa - sb : sa + sb;
    v     = (exact > SMAX) || (exact < SMIN);
    c     = o[0] ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF);
    r     = o[0] ? a - b : a + b;
    if (o[1] && v) r = (exact > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    z     = (r == 32'h0);
  endfunction

  typedef struct {
    logic [31:0]      res;
    logic             c;
    logic             v;
    logic             z;
    logic [TAG_W-1:0] tag;
    int               age;
  } op_t;

  op_t              pipe_q[$];
  logic             exp_valid = 1'b0;
  logic [31:0]      exp_res   = '0;
  logic             exp_c     = 1'b0;
  logic             exp_v     = 1'b0;
  logic             exp_z     = 1'b0;
  logic [TAG_W-1:0] exp_tag   = '0;

  // An accepted op emerges after it has seen NSEG unstalled edges; outputs hold otherwise.
  always @(posedge clock or posedge reset) begin
    op_t n;
    if (reset) begin
      pipe_q.delete();
      exp_valid = 1'b0;
      exp_res   = '0;
      exp_c     = 1'b0;
      exp_v     = 1'b0;
      exp_z     = 1'b0;
      exp_tag   = '0;
    end else if (!stall) begin
      for (int i = 0; i < pipe_q.size(); i++) pipe_q[i].age++;
      if (in_valid) begin
        model_op(a_in, b_in, op, n.res, n.c, n.v, n.z);
        n.tag = tag_in;
        n.age = 1;
        pipe_q.push_back(n);
      end
      exp_valid = 1'b0;
      if (pipe_q.size() > 0 && pipe_q[0].age >= NSEG) begin
        n = pipe_q.pop_front();
        exp_valid = 1'b1;
        exp_res   = n.res;
        exp_c     = n.c;
        exp_v     = n.v;
        exp_z     = n.z;
        exp_tag   = n.tag;
      end
    end
  end

  task automatic check_output();
    check("model out_valid", 32'(out_valid), 32'(exp_valid));
    check("model result", result, exp_res);
    check("model cout", 32'(cout), 32'(exp_c));
    check("model ovf", 32'(ovf), 32'(exp_v));
    check("model zero", 32'(zero), 32'(exp_z));
    check("model tag_out", 32'(tag_out), 32'(exp_tag));
  endtask

  always @(negedge clock) begin
    if (check_en) check_output();
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] o, input logic [TAG_W-1:0] t, input logic s);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    op       = o;
    tag_in   = t;
    stall    = s;
    @(posedge clock);
    #1;
  endtask

  task automatic run_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] o, input logic [TAG_W-1:0] t,
                              input logic [31:0] er, input logic ec, input logic ev,
                              input logic ez);
    int lat;
    apply_stimulus(1'b1, a, b, o, t, 1'b0);
    lat = 1;
    while (!out_valid && lat < 12) begin
      apply_stimulus(1'b0, '0, '0, '0, '0, 1'b0);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(NSEG));
    check({name, " result"}, result, er);
    check({name, " cout"}, 32'(cout), 32'(ec));
    check({name, " ovf"}, 32'(ovf), 32'(ev));
    check({name, " zero"}, 32'(zero), 32'(ez));
    check({name, " tag"}, 32'(tag_out), 32'(t));
    apply_stimulus(1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  // Four ops tagged 0..3; the stalled variant freezes two cycles after the 2nd issue
  // and offers a tag-7 op during the stall that must never come out.
  task automatic run_burst(input bit with_stall);
    logic             rec_v[10];
    logic [TAG_W-1:0] rec_t[10];
    int n_in, first, k;
    n_in  = with_stall ? 6 : 4;
    first = with_stall ? 5 : 3;
    for (int i = 0; i < 10; i++) begin
      if (i < n_in) begin
        if (with_stall && (i == 2 || i == 3)) begin
          apply_stimulus(i == 2, 32'hDEAD_0000, 32'h1, 2'b00, 5'd7, 1'b1);
        end else begin
          k = (with_stall && i > 3) ? i - 2 : i;
          apply_stimulus(1'b1, 32'h1111_1111 * (k + 1), 32'h0F0F_0F0F + k, 2'(k), 5'(k), 1'b0);
        end
      end else begin
        apply_stimulus(1'b0, '0, '0, '0, '0, 1'b0);
      end
      rec_v[i] = out_valid;
      rec_t[i] = tag_out;
    end
    for (int i = 0; i < 10; i++) begin
      check($sformatf("burst%0d out_valid@%0d", with_stall, i), 32'(rec_v[i]),
            32'(i >= first && i < first + 4));
      if (i >= first && i < first + 4)
        check($sformatf("burst%0d tag@%0d", with_stall, i), 32'(rec_t[i]), 32'(i - first));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset result", result, 32'h0);
    check("reset cout", 32'(cout), 32'h0);
    check("reset ovf", 32'(ovf), 32'h0);
    check("reset zero", 32'(zero), 32'h0);
    check("reset tag_out", 32'(tag_out), 32'h0);
    reset    = 1'b0;
    check_en = 1'b1;

    run_directed("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 5'd3, 32'h0000_0000, 1, 0, 1);
    run_directed("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 5'd4, 32'h8000_0000, 0, 1, 0);
    run_directed("addsat",     32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 5'd5, 32'h7FFF_FFFF, 0, 1, 0);
    run_directed("sub_eq",     32'h0000_0005, 32'h0000_0005, 2'b01, 5'd6, 32'h0000_0000, 1, 0, 1);
    run_directed("sub_neg",    32'h0000_0003, 32'h0000_0005, 2'b01, 5'd7, 32'hFFFF_FFFE, 0, 0, 0);
    run_directed("subsat",     32'h8000_0000, 32'h0000_0001, 2'b11, 5'd8, 32'h8000_0000, 1, 1, 0);

    run_burst(1'b0);
    run_burst(1'b1);

    apply_stimulus(1'b1, 32'h0000_1234, 32'h0000_0001, 2'b00, 5'd10, 1'b0);
    apply_stimulus(1'b1, 32'h0000_5678, 32'h0000_0002, 2'b00, 5'd11, 1'b0);
    in_valid = 1'b1;
    a_in     = 32'h0000_9ABC;
    tag_in   = 5'd12;
    reset    = 1'b1;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'h0);
    check("midreset result", result, 32'h0);
    check("midreset tag_out", 32'(tag_out), 32'h0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, '0, '0, '0, '0, 1'b0);
      check($sformatf("postreset quiet@%0d", i), 32'(out_valid), 32'h0);
    end
    run_directed("postreset", 32'h0000_00FF, 32'h0000_0001, 2'b00, 5'd9, 32'h0000_0100, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      ra = pick();
      rb = pick();
      apply_stimulus($urandom_range(0, 99) < 70, ra, rb, 2'($urandom_range(0, 3)),
                     5'($urandom_range(0, 31)), $urandom_range(0, 99) < 15);
    end
    repeat (8) apply_stimulus(1'b0, '0, '0, '0, '0, 1'b0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub_unit.md
Name: pipelined_addsub_unit

Overview:
Parametrised, pipelined integer add/subtract unit and the successor to the fixed 32-bit single-cycle adder. Operands are split into SEG_W-bit segments. One segment is resolved per pipeline stage, and the carry is registered between stages, so the clock period is bounded by a SEG_W-bit add. It adds signed saturating modes, carry/zero flags, a pass-through tag and a global stall, and it sits in the execute stage as the multi-cycle ALU arithmetic path.

Parameters:
WIDTH, 32, operand/result width; must be an integer multiple of SEG_W.
SEG_W, 8, bits resolved per stage; NSEG = WIDTH/SEG_W stages, NSEG >= 1.
TAG_W, 5, width of the opaque tag (e.g. destination register) carried alongside each op.

Ports:
clock      in   1        rising-edge clock
reset      in   1        asynchronous, active-high reset
in_valid   in   1        operation present on A/B/op/tag this cycle
A          in   WIDTH    operand A (two's complement when signed semantics apply)
B          in   WIDTH    operand B
op         in   2        00 ADD, 01 SUB (A-B), 10 ADDSAT (signed saturating), 11 SUBSAT
tag_in     in   TAG_W    tag captured with the op
stall      in   1        1 = freeze the whole pipeline; in_valid is ignored
out_valid  out  1        result/flags/tag_out valid
result     out  WIDTH    sum/difference, clamped in SAT modes
cout       out  1        carry out of the MSB (SUB: 1 = no borrow); computed before saturation
ovf        out  1        signed overflow, i.e. carry into MSB XOR carry out of MSB
zero       out  1        result == 0, evaluated after saturation
tag_out    out  TAG_W    tag of the op in the result

Behaviour:
- Reset, asynchronous: all pipeline valid bits clear to 0. out_valid, result, cout, ovf, zero and tag_out are all 0. Data registers are also cleared to 0.
- Subtract: B is inverted per bit and the carry-in is set to 1 for op[0]=1. No external carry-in exists.
- Stage k (1..NSEG): adds segment k-1 of A and B_mod with the carry registered from stage k-1; stage 1 uses the op-derived carry-in.
  - Each stage registers its sum segment, carry out, the not-yet-consumed upper operand segments, the op and the tag.
  - Lower result segments are skew-delayed so all segments align at the output.
- Stage NSEG also computes cout, ovf, saturation and zero, and registers them into the output registers.
- Latency: an op accepted at edge N (in_valid=1, stall=0) appears with out_valid=1 after edge N+NSEG-1. That is NSEG cycles from issue to first visible output.
- Throughput: one op per cycle, with results returned strictly in order.
- Saturation (op[1]=1), applied only when ovf=1:
  - A and B_mod sign bits both 0 gives result 2^(WIDTH-1)-1.
  - Both 1 gives result -2^(WIDTH-1).
  - ovf is still reported as 1.
  - With ovf=0, the SAT modes are identical to ADD/SUB.
- out_valid: a single-cycle pulse per op unless stalled. With in_valid=0 the bubbles propagate and out_valid=0.
- Output data registers update only when a valid op reaches the output. Otherwise result/flags/tag_out hold their last valid value.
- Stall=1: every pipeline and output register holds, out_valid holds its value, and the input is not captured. When stall falls, progression resumes from the held state with no op lost or duplicated.
- Simultaneous in_valid=1 and stall=1: the op is dropped. The issuer must hold it until stall=0.
- Reset asserted mid-flight: all in-flight ops are discarded, and no stale out_valid follows release.
- NSEG=1: degenerates to a single registered adder with latency 1.
- Elaboration fails if WIDTH % SEG_W != 0.

Test Plan:
WIDTH=32, SEG_W=8 (latency 4), TAG_W=5.
1. ADD 0xFFFFFFFF+0x00000001, tag 3 -> 4 cycles later: result 0x00000000, cout=1, zero=1, ovf=0, tag_out=3 (carry ripples through all 4 stages).
2. ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1, cout=0. ADDSAT with the same operands -> 0x7FFFFFFF, ovf=1, zero=0.
3. SUB 5-5 -> 0, zero=1, cout=1. SUB 3-5 -> 0xFFFFFFFE, cout=0, ovf=0. SUBSAT 0x80000000-1 -> 0x80000000, ovf=1.
4. Four back-to-back ops with tags 0..3 -> out_valid high on 4 consecutive cycles, in-order tags and correct sums.
5. Repeat scenario 4 with stall=1 for 2 cycles after the 2nd issue -> outputs freeze for exactly 2 cycles, then resume; no loss or duplication. An in_valid pulse during the stall produces no result.
6. Issue 3 ops, then assert reset for 1 cycle after the 2nd edge -> outputs go to 0 immediately and out_valid stays 0 for 6 following cycles. A fresh op afterwards returns correctly at latency 4.
